// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control/hazard unit: PC-source select, stall/flush generation, MULT/DIV busy tracking, EPC/Cause/EXL.
// Latency: redirect/stall/flush are combinational (same cycle); EPC/Cause/EXL and MD busy update on the next edge.
// Backpressure: stalls the front end by dropping pc_we/if_id_we and bubbling ID on load-use or MD hazards.
module pipe_hazard_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter int                REG_AW  = 5,
    parameter int                MD_LAT  = 4,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(32'h0000_0180)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_jump_target,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic              ex_md_start,
    input  logic              mem_exc_req,
    input  logic [4:0]        mem_exc_code,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic              mem_eret,
    output logic [1:0]        pc_sel,
    output logic [ADDR_W-1:0] pc_redirect,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic              md_busy,
    output logic [ADDR_W-1:0] epc,
    output logic [4:0]        cause,
    output logic              exl
);

    localparam int              CNT_W   = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // The PC mux outside owns the vector value; it must be a word address.
    if (EXC_VEC[1:0] != 2'b00) begin : g_bad_vec
        $error("EXC_VEC must be word aligned");
    end
    if (MD_LAT < 1) begin : g_bad_lat
        $error("MD_LAT must be at least 1");
    end

    logic [ADDR_W-1:0] r_epc;
    logic [4:0]        r_cause;
    logic              r_exl;
    logic [CNT_W-1:0]  r_md_cnt;

    logic w_uses_rs;
    logic w_uses_rt;
    logic w_load_use;
    logic w_md_op;
    logic w_md_hazard;
    logic w_exc_take;
    logic w_eret_take;

    assign w_uses_rs   = (id_opcode != 6'h02) && (id_opcode != 6'h03);
    assign w_uses_rt   = id_opcode inside {6'h00, 6'h04, 6'h05, 6'h2b};
    assign w_load_use  = ex_mem_read && (ex_rt != '0) &&
                         (((ex_rt == id_rs) && w_uses_rs) || ((ex_rt == id_rt) && w_uses_rt));
    assign w_md_op     = (id_opcode == 6'h00) &&
                         (id_funct inside {6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b});
    assign w_md_hazard = md_busy && w_md_op;
    // An exception arriving while already in the handler is dropped, not queued.
    assign w_exc_take  = rst_n && mem_exc_req && !r_exl;
    assign w_eret_take = rst_n && mem_eret && !w_exc_take;

    assign md_busy = (r_md_cnt != '0);
    assign epc     = r_epc;
    assign cause   = r_cause;
    assign exl     = r_exl;

    always_comb begin
        pc_sel      = 2'd0;
        pc_redirect = '0;
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        mem_flush   = 1'b0;
        if (w_exc_take) begin
            pc_sel    = 2'd2;
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
        end else if (w_eret_take) begin
            pc_sel   = 2'd3;
            if_flush = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end else if (rst_n && ex_branch_taken) begin
            pc_sel      = 2'd1;
            pc_redirect = ex_branch_target;
            if_flush    = 1'b1;
            id_flush    = 1'b1;
        end else if (rst_n && (w_load_use || w_md_hazard)) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_flush = 1'b1;
        end else if (rst_n && id_jump) begin
            pc_sel      = 2'd1;
            pc_redirect = id_jump_target;
            if_flush    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_epc    <= '0;
            r_cause  <= '0;
            r_exl    <= 1'b0;
            r_md_cnt <= '0;
        end else begin
            if (w_exc_take) begin
                r_epc   <= mem_pc;
                r_cause <= mem_exc_code;
                r_exl   <= 1'b1;
            end else if (w_eret_take) begin
                r_exl <= 1'b0;
            end
            if (ex_md_start) begin
                r_md_cnt <= MD_LOAD;
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, ex_rt, mem_exc_code;
    logic        id_jump, ex_mem_read, ex_branch_taken, ex_md_start, mem_exc_req, mem_eret;
    logic [31:0] id_jump_target, ex_branch_target, mem_pc;
    logic [1:0]  pc_sel;
    logic [31:0] pc_redirect, epc;
    logic        pc_we, if_id_we, if_flush, id_flush, ex_flush, mem_flush, md_busy, exl;
    logic [4:0]  cause;

    pipe_hazard_ctrl #(.ADDR_W(32), .REG_AW(5), .MD_LAT(MD_LAT), .EXC_VEC(32'h0000_0180)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
        .id_jump(id_jump), .id_jump_target(id_jump_target),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .ex_md_start(ex_md_start),
        .mem_exc_req(mem_exc_req), .mem_exc_code(mem_exc_code), .mem_pc(mem_pc),
        .mem_eret(mem_eret),
        .pc_sel(pc_sel), .pc_redirect(pc_redirect), .pc_we(pc_we), .if_id_we(if_id_we),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .md_busy(md_busy), .epc(epc), .cause(cause), .exl(exl)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model state
    int          m_md_left = 0;
    logic [31:0] m_epc = '0;
    logic [4:0]  m_cause = '0;
    logic        m_exl = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current inputs and model state, derived from the priority rules.
    task automatic compare_model();
        logic [1:0]  e_sel;
        logic [31:0] e_red;
        logic        e_pcwe, e_ifidwe, uses_rs, uses_rt, lu, mdop, busy;
        logic [3:0]  e_fl;
        e_sel = 0; e_red = 0; e_pcwe = 1; e_ifidwe = 1; e_fl = 4'b0000;
        busy = (m_md_left > 0);
        uses_rs = !(id_opcode == 6'd2 || id_opcode == 6'd3);
        uses_rt = (id_opcode == 6'd0 || id_opcode == 6'd4 || id_opcode == 6'd5 || id_opcode == 6'h2b);
        lu = ex_mem_read && ex_rt != 0 && ((ex_rt == id_rs && uses_rs) || (ex_rt == id_rt && uses_rt));
        mdop = id_opcode == 0 && (id_funct == 6'h10 || id_funct == 6'h12 ||
                                  (id_funct >= 6'h18 && id_funct <= 6'h1b));
        if (rst_n) begin
            if (mem_exc_req && !m_exl) begin
                e_sel = 2; e_fl = 4'b1111;
            end else if (mem_eret) begin
                e_sel = 3; e_fl = 4'b1110;
            end else if (ex_branch_taken) begin
                e_sel = 1; e_red = ex_branch_target; e_fl = 4'b1100;
            end else if (lu || (busy && mdop)) begin
                e_pcwe = 0; e_ifidwe = 0; e_fl = 4'b0100;
            end else if (id_jump) begin
                e_sel = 1; e_red = id_jump_target; e_fl = 4'b1000;
            end
        end
        chk("pc_sel", 64'(pc_sel), 64'(e_sel));
        chk("pc_redirect", 64'(pc_redirect), 64'(e_red));
        chk("we{pc,ifid}", 64'({pc_we, if_id_we}), 64'({e_pcwe, e_ifidwe}));
        chk("flush{if,id,ex,mem}", 64'({if_flush, id_flush, ex_flush, mem_flush}), 64'(e_fl));
        chk("md_busy", 64'(md_busy), 64'(busy));
        chk("epc/cause/exl", {27'd0, exl, cause, epc}, {27'd0, m_exl, m_cause, m_epc});
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_epc = 0; m_cause = 0; m_exl = 0; m_md_left = 0;
        end else begin
            if (mem_exc_req && !m_exl) begin
                m_epc = mem_pc; m_cause = mem_exc_code; m_exl = 1;
            end else if (mem_eret) begin
                m_exl = 0;
            end
            if (ex_md_start) m_md_left = MD_LAT;
            else if (m_md_left > 0) m_md_left--;
        end
    endtask

    // Called at posedge+1: settle to mid-cycle and check against the model.
    task automatic settle();
        #4;
        compare_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        id_opcode = 6'h08; id_funct = 6'h00; id_rs = 5'd1; id_rt = 5'd2;
        id_jump = 0; id_jump_target = 0; ex_mem_read = 0; ex_rt = 0;
        ex_branch_taken = 0; ex_branch_target = 0; ex_md_start = 0;
        mem_exc_req = 0; mem_exc_code = 0; mem_pc = 0; mem_eret = 0;
    endtask

    task automatic rand_inputs();
        logic [5:0] ops[8]   = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h08};
        logic [5:0] fns[8]   = '{6'h20, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h22};
        rst_n            = ($urandom_range(0, 199) != 0);
        id_opcode        = ops[$urandom_range(0, 7)];
        id_funct         = fns[$urandom_range(0, 7)];
        id_rs            = 5'($urandom_range(0, 3));
        id_rt            = 5'($urandom_range(0, 3));
        id_jump          = ($urandom_range(0, 7) == 0);
        id_jump_target   = $urandom;
        ex_mem_read      = ($urandom_range(0, 2) == 0);
        ex_rt            = 5'($urandom_range(0, 3));
        ex_branch_taken  = ($urandom_range(0, 7) == 0);
        ex_branch_target = $urandom;
        ex_md_start      = ($urandom_range(0, 9) == 0);
        mem_exc_req      = ($urandom_range(0, 15) == 0);
        mem_exc_code     = 5'($urandom);
        mem_pc           = $urandom;
        mem_eret         = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        int n;
        idle_inputs();
        rst_n = 0;
        mem_exc_req = 1; mem_exc_code = 5'd12; mem_pc = 32'h0040_0020; mem_eret = 1;
        advance();
        advance();
        // Reset held with a pending exception/ERET
        settle();
        chk("rst_exl", 64'(exl), 64'd0);
        chk("rst_epc", 64'(epc), 64'd0);
        chk("rst_pc_sel", 64'(pc_sel), 64'd0);
        chk("rst_pc_we", 64'(pc_we), 64'd1);
        advance();
        rst_n = 1; idle_inputs();

        // Load-use: add with rt matching the load destination
        ex_mem_read = 1; ex_rt = 5'd5; id_opcode = 6'h00; id_funct = 6'h20; id_rs = 5'd1; id_rt = 5'd5;
        settle();
        chk("lu_stall", 64'({pc_we, if_id_we, id_flush}), 64'b001);
        advance();
        ex_rt = 5'd0; id_rt = 5'd0;
        settle();
        chk("lu_r0_nostall", 64'({pc_we, if_id_we, id_flush}), 64'b110);
        advance();
        ex_rt = 5'd5; id_opcode = 6'h02; id_rs = 5'd5; id_rt = 5'd5;
        settle();
        chk("lu_jump_nostall", 64'({pc_we, if_id_we, id_flush}), 64'b110);
        advance();
        idle_inputs();

        // Exception, ignored nested exception, then ERET
        mem_exc_req = 1; mem_exc_code = 5'd12; mem_pc = 32'h0040_0020;
        settle();
        chk("exc_pc_sel", 64'(pc_sel), 64'd2);
        chk("exc_flush", 64'({if_flush, id_flush, ex_flush, mem_flush}), 64'hf);
        advance();
        mem_exc_code = 5'd4; mem_pc = 32'h0040_0099;
        settle();
        chk("exc_epc", 64'(epc), 64'h0040_0020);
        chk("exc_cause", 64'(cause), 64'd12);
        chk("exc_exl", 64'(exl), 64'd1);
        chk("exc_nested_ignored", 64'(pc_sel), 64'd0);
        advance();
        mem_exc_req = 0; mem_eret = 1;
        settle();
        chk("nested_epc_kept", 64'(epc), 64'h0040_0020);
        chk("eret_pc_sel", 64'(pc_sel), 64'd3);
        advance();
        mem_eret = 0;
        settle();
        chk("eret_exl", 64'(exl), 64'd0);
        advance();

        // MD busy stall on MFLO lasts exactly MD_LAT cycles
        ex_md_start = 1;
        settle();
        advance();
        ex_md_start = 0; id_opcode = 6'h00; id_funct = 6'h12;
        n = 0;
        while (n < 20) begin
            settle();
            if (pc_we === 1'b1) break;
            n++;
            advance();
        end
        if (n >= 20) chk("md_release_timeout", 64'(n), 64'd4);
        chk("md_stall_cycles", 64'(n), 64'd4);
        advance();
        id_funct = 6'h10;
        settle();
        chk("mfhi_idle_nostall", 64'({pc_we, if_id_we, md_busy}), 64'b110);
        advance();
        idle_inputs();

        // Taken branch beats same-cycle load-use
        ex_branch_taken = 1; ex_branch_target = 32'h0040_0100;
        ex_mem_read = 1; ex_rt = 5'd3; id_opcode = 6'h00; id_rs = 5'd3;
        settle();
        chk("br_pc_sel", 64'(pc_sel), 64'd1);
        chk("br_redirect", 64'(pc_redirect), 64'h0040_0100);
        chk("br_flush_we", 64'({if_flush, id_flush, pc_we}), 64'b111);
        advance();
        idle_inputs();

        id_jump = 1; id_jump_target = 32'h0040_0200;
        settle();
        chk("jmp_pc_sel", 64'(pc_sel), 64'd1);
        chk("jmp_redirect", 64'(pc_redirect), 64'h0040_0200);
        chk("jmp_flush", 64'({if_flush, id_flush}), 64'b10);
        advance();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
